// File: rtl/maxmin4_seq_sorter_if.sv
// rtl/maxmin4_seq_sorter_if.sv - operand/result handshake bundle for maxmin4_seq_sorter
//
// Purpose: groups the producer-side and consumer-side handshakes and data of the
// four-operand sequential sorter.
// Signals:
//   in_valid/in_ready  : operand set handshake (producer -> sorter)
//   A,B,C,D            : operands 0..3, WIDTH-bit unsigned
//   out_valid/out_ready: result handshake (sorter -> consumer)
//   max,midH,midL,min  : sorted result, non-increasing
//   busy               : sorter is in SORT or DONE
// Modports: master = producer/consumer side, slave = sorter side.
interface maxmin4_seq_sorter_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] D;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] max;
    logic [WIDTH-1:0] midH;
    logic [WIDTH-1:0] midL;
    logic [WIDTH-1:0] min;
    logic             busy;

    modport master (
        output in_valid, A, B, C, D, out_ready,
        input  in_ready, out_valid, max, midH, midL, min, busy
    );

    modport slave (
        input  in_valid, A, B, C, D, out_ready,
        output in_ready, out_valid, max, midH, midL, min, busy
    );
endinterface

// File: rtl/maxmin4_seq_sorter.sv
// rtl/maxmin4_seq_sorter.sv - four-operand sorter sharing one compare-exchange unit
//
// Purpose: loads A..D into slots s0..s3, then runs a 5-step sorting network
// (0,1) (2,3) (0,2) (1,3) (1,2) on a single compare-exchange unit, one step per
// clock, leaving s0>=s1>=s2>=s3. Result is held until the consumer accepts it.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of maxmin4_seq_sorter_if (operand and result handshakes,
//           sorted outputs driven straight from the slot registers, busy)
module maxmin4_seq_sorter #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    maxmin4_seq_sorter_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [2:0]       r_step;
    logic [WIDTH-1:0] r_slot [4];

    logic [1:0]       w_i;
    logic [1:0]       w_j;
    logic             w_swap;
    logic             w_accept;

    assign w_accept = (r_state == IDLE) && bus.in_valid;

    // Pair selection for the current network step; the larger value moves to
    // the lower slot index.
    always_comb begin
        w_i = 2'd1;
        w_j = 2'd2;
        case (r_step)
            3'd0: begin w_i = 2'd0; w_j = 2'd1; end
            3'd1: begin w_i = 2'd2; w_j = 2'd3; end
            3'd2: begin w_i = 2'd0; w_j = 2'd2; end
            3'd3: begin w_i = 2'd1; w_j = 2'd3; end
            default: begin w_i = 2'd1; w_j = 2'd2; end
        endcase
    end

    // Strict compare: equal values are left in place.
    assign w_swap = (r_slot[w_j] > r_slot[w_i]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next_state = SORT;
            SORT: if (r_step == 3'd4) w_next_state = DONE;
            DONE: if (bus.out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Slot and step datapath. Only the two selected slots are written in SORT;
    // slots keep the last result through DONE and IDLE until a new load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step <= 3'd0;
            for (int k = 0; k < 4; k++) begin
                r_slot[k] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_slot[0] <= bus.A;
                        r_slot[1] <= bus.B;
                        r_slot[2] <= bus.C;
                        r_slot[3] <= bus.D;
                        r_step    <= 3'd0;
                    end
                end
                SORT: begin
                    if (w_swap) begin
                        r_slot[w_i] <= r_slot[w_j];
                        r_slot[w_j] <= r_slot[w_i];
                    end
                    if (r_step != 3'd4) begin
                        r_step <= r_step + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.max       = r_slot[0];
    assign bus.midH      = r_slot[1];
    assign bus.midL      = r_slot[2];
    assign bus.min       = r_slot[3];
endmodule

// File: tb/tb_maxmin4_seq_sorter.sv
// tb/tb_maxmin4_seq_sorter.sv - self-checking bench for maxmin4_seq_sorter
module tb_maxmin4_seq_sorter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    maxmin4_seq_sorter_if #(.WIDTH(8)) bus ();

    maxmin4_seq_sorter #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a, b, c, d;
        logic [7:0] emax, emh, eml, emin;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Reference: plain insertion sort, descending; returns {max,midH,midL,min}.
    function automatic logic [31:0] ref_sort(input logic [7:0] a, b, c, d);
        logic [7:0] v [4];
        logic [7:0] t;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int p = 1; p < 4; p++) begin
            for (int q = p; q > 0; q--) begin
                if (v[q] > v[q-1]) begin
                    t = v[q]; v[q] = v[q-1]; v[q-1] = t;
                end
            end
        end
        return {v[0], v[1], v[2], v[3]};
    endfunction

    // Offers a set at a negedge once in_ready is seen; returns at the negedge
    // right after the accepting edge.
    task automatic send(input logic [7:0] a, b, c, d);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
        bus.A = a; bus.B = b; bus.C = c; bus.D = d;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Counts negedges until out_valid; optionally drives ignored garbage.
    task automatic wait_result(input bit garbage, output int cnt);
        cnt = 0;
        while (!bus.out_valid && cnt < 40) begin
            if (garbage) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.A = 8'($urandom); bus.B = 8'($urandom);
                bus.C = 8'($urandom); bus.D = 8'($urandom);
            end
            @(negedge clk);
            cnt++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_out(input string name, input logic [31:0] exp);
        chk({name, "_max"},  32'(bus.max),  32'(exp[31:24]));
        chk({name, "_midH"}, 32'(bus.midH), 32'(exp[23:16]));
        chk({name, "_midL"}, 32'(bus.midL), 32'(exp[15:8]));
        chk({name, "_min"},  32'(bus.min),  32'(exp[7:0]));
    endtask

    initial begin
        int cnt;
        logic [31:0] e;
        logic [7:0] ra, rb, rc, rd;
        checks = 0;
        errors = 0;

        vecs[0] = '{8'd3,   8'd200, 8'd17,  8'd90,  8'd200, 8'd90,  8'd17,  8'd3};
        vecs[1] = '{8'h55,  8'h55,  8'h55,  8'h55,  8'h55,  8'h55,  8'h55,  8'h55};
        vecs[2] = '{8'd255, 8'd0,   8'd255, 8'd0,   8'd255, 8'd255, 8'd0,   8'd0};
        vecs[3] = '{8'd1,   8'd2,   8'd3,   8'd4,   8'd4,   8'd3,   8'd2,   8'd1};
        vecs[4] = '{8'd0,   8'd0,   8'd0,   8'd255, 8'd255, 8'd0,   8'd0,   8'd0};
        vecs[5] = '{8'd9,   8'd8,   8'd7,   8'd6,   8'd9,   8'd8,   8'd7,   8'd6};
        vecs[6] = '{8'd10,  8'd10,  8'd5,   8'd20,  8'd20,  8'd10,  8'd10,  8'd5};
        vecs[7] = '{8'd128, 8'd127, 8'd129, 8'd1,   8'd129, 8'd128, 8'd127, 8'd1};

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.A = '0; bus.B = '0; bus.C = '0; bus.D = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk_out("rst", 32'd0);

        // Directed table, consumer always ready.
        for (int v = 0; v < 8; v++) begin
            send(vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].d);
            wait_result(1'b0, cnt);
            chk("tbl_latency", 32'(cnt), 32'd5);
            chk_out("tbl", {vecs[v].emax, vecs[v].emh, vecs[v].eml, vecs[v].emin});
            @(negedge clk);
            chk("tbl_in_ready_back", 32'(bus.in_ready), 32'd1);
            chk("tbl_out_valid_drop", 32'(bus.out_valid), 32'd0);
        end

        // Backpressure: result held, new set refused while in DONE.
        bus.out_ready = 1'b0;
        send(8'd5, 8'd6, 8'd7, 8'd8);
        wait_result(1'b0, cnt);
        chk("bp_latency", 32'(cnt), 32'd5);
        bus.A = 8'd50; bus.B = 8'd70; bus.C = 8'd60; bus.D = 8'd40;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
            chk_out("bp_hold", {8'd8, 8'd7, 8'd6, 8'd5});
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle_in_ready", 32'(bus.in_ready), 32'd1);
        chk_out("bp_idle_hold", {8'd8, 8'd7, 8'd6, 8'd5});
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp_new_busy", 32'(bus.busy), 32'd1);
        wait_result(1'b0, cnt);
        chk("bp_new_latency", 32'(cnt), 32'd5);
        chk_out("bp_new", {8'd70, 8'd60, 8'd50, 8'd40});
        @(negedge clk);

        // Reset pulse while step 2 is pending.
        send(8'd10, 8'd20, 8'd30, 8'd40);
        repeat (2) @(negedge clk);
        chk("rp_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rp_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rp_busy",      32'(bus.busy),      32'd0);
        chk("rp_in_ready",  32'(bus.in_ready),  32'd1);
        chk_out("rp", 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'd1, 8'd2, 8'd3, 8'd4);
        wait_result(1'b0, cnt);
        chk("rp_next_latency", 32'(cnt), 32'd5);
        chk_out("rp_next", {8'd4, 8'd3, 8'd2, 8'd1});
        @(negedge clk);

        // Random sets with producer gaps, ignored garbage and consumer stalls.
        bus.out_ready = 1'b0;
        for (int s = 0; s < 1000; s++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ra = 8'($urandom); rb = 8'($urandom);
            rc = 8'($urandom); rd = 8'($urandom);
            if (s % 10 == 0) begin
                rb = ra;
                rd = (s % 20 == 0) ? 8'd255 : 8'd0;
            end
            e = ref_sort(ra, rb, rc, rd);
            send(ra, rb, rc, rd);
            wait_result(1'b1, cnt);
            chk("rnd_latency", 32'(cnt), 32'd5);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chk("rnd_stall_valid", 32'(bus.out_valid), 32'd1);
            end
            chk_out("rnd", e);
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            chk("rnd_no_dup", 32'(bus.out_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
